// File: rtl/shift_arbiter_ctrl.sv
// Two-requester round-robin front end to one shared 32-bit left shifter with a one-entry response buffer.
// Optional rotate-right on op 11 is enabled by defining SHIFT_ROR_EN.

module shift_left32 (
    input  logic [31:0] a,
    input  logic [4:0]  s,
    output logic [31:0] lo,
    output logic [31:0] hi
);
    // hi keeps the bits pushed out of the top so callers can build a rotate from one pass
    logic [63:0] wide;

    assign wide = {32'h0, a} << s;
    assign lo   = wide[31:0];
    assign hi   = wide[63:32];
endmodule

module shift_arbiter_ctrl #(
    parameter int RR_INIT = 0,
    parameter int XLEN    = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [1:0]      req0_op,
    input  logic [XLEN-1:0] req0_data,
    input  logic [4:0]      req0_shamt,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [1:0]      req1_op,
    input  logic [XLEN-1:0] req1_data,
    input  logic [4:0]      req1_shamt,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_id,
    output logic [XLEN-1:0] rsp_data
);
    typedef enum logic {EMPTY, FULL} state_t;

    state_t      state;
    logic        ptr;
    logic        can_accept;
    logic        grant0;
    logic        grant1;
    logic        grant;
    logic [1:0]  sel_op;
    logic [31:0] sel_data;
    logic [4:0]  sel_shamt;
    logic [31:0] shift_in;
    logic [31:0] sh_lo;
    logic [31:0] sh_hi;
    logic [31:0] srl_res;
    logic [31:0] fill;
    logic [31:0] result;

    function automatic logic [31:0] rev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

    assign rsp_valid  = (state == FULL);
    assign can_accept = !rst && (!rsp_valid || rsp_ready);
    assign grant0     = can_accept && req0_valid && (!req1_valid || !ptr);
    assign grant1     = can_accept && req1_valid && (!req0_valid || ptr);
    assign grant      = grant0 || grant1;
    assign req0_ready = grant0;
    assign req1_ready = grant1;

    assign sel_op    = grant1 ? req1_op    : req0_op;
    assign sel_data  = grant1 ? req1_data  : req0_data;
    assign sel_shamt = grant1 ? req1_shamt : req0_shamt;

    // Right shifts run through the left shifter on the bit-reversed operand
    assign shift_in = (sel_op == 2'b00) ? sel_data : rev32(sel_data);

    shift_left32 u_shift (
        .a  (shift_in),
        .s  (sel_shamt),
        .lo (sh_lo),
        .hi (sh_hi)
    );

    assign srl_res = rev32(sh_lo);

    // Sign-fill mask: the top sel_shamt bits set
    always_comb begin
        fill = '0;
        for (int i = 0; i < 32; i++) begin
            fill[i] = (5'(31 - i) < sel_shamt);
        end
    end

    always_comb begin
        result = '0;
        case (sel_op)
            2'b00:   result = sh_lo;
            2'b01:   result = srl_res;
            2'b10:   result = srl_res | (sel_data[31] ? fill : 32'h0);
`ifdef SHIFT_ROR_EN
            // Bits spilled out of the reversed shift are exactly the wrap-around part
            default: result = rev32(sh_lo | sh_hi);
`else
            default: result = 32'h0;
`endif
        endcase
    end

`ifndef SHIFT_ROR_EN
    logic unused_hi;
    assign unused_hi = ^sh_hi;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= EMPTY;
            rsp_id   <= 1'b0;
            rsp_data <= '0;
            ptr      <= 1'(RR_INIT);
        end else begin
            if (grant) begin
                rsp_id   <= grant1;
                rsp_data <= result;
                ptr      <= grant0;
            end
            case (state)
                EMPTY: if (grant) state <= FULL;
                FULL:  if (rsp_ready && !grant) state <= EMPTY;
                default: state <= EMPTY;
            endcase
        end
    end
endmodule

// File: tb/tb_shift_arbiter_ctrl.sv
// Self-checking bench for shift_arbiter_ctrl: scoreboard of expected responses plus scenario checks.
// Expected rotate results follow SHIFT_ROR_EN.

module tb_shift_arbiter_ctrl;
    logic        clk;
    logic        rst;
    logic        req0_valid;
    logic        req0_ready;
    logic [1:0]  req0_op;
    logic [31:0] req0_data;
    logic [4:0]  req0_shamt;
    logic        req1_valid;
    logic        req1_ready;
    logic [1:0]  req1_op;
    logic [31:0] req1_data;
    logic [4:0]  req1_shamt;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [31:0] rsp_data;

    int errors = 0;
    int checks = 0;
    logic [32:0] sb[$];

    shift_arbiter_ctrl #(.RR_INIT(0), .XLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_data  (req0_data),
        .req0_shamt (req0_shamt),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_data  (req1_data),
        .req1_shamt (req1_shamt),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] x, input logic [4:0] s);
        logic signed [31:0] sx;
        sx = x;
        case (op)
            2'b00: return x << s;
            2'b01: return x >> s;
            2'b10: return sx >>> s;
`ifdef SHIFT_ROR_EN
            default: return (s == 5'd0) ? x : ((x >> s) | (x << (32 - int'(s))));
`else
            default: return 32'h0;
`endif
        endcase
    endfunction

    // Called just after a falling edge with inputs driven; returns at the next falling edge
    task automatic cycle();
        logic [32:0] exp;
        #1;
        if (rsp_valid && rsp_ready && !rst) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("[TB] FAIL sb_unexpected: got id=%0d data=%h, required no response", rsp_id, rsp_data);
            end else begin
                exp = sb.pop_front();
                if ({rsp_id, rsp_data} !== exp) begin
                    errors++;
                    $display("[TB] FAIL sb_rsp: got id=%0d data=%h, required id=%0d data=%h",
                             rsp_id, rsp_data, exp[32], exp[31:0]);
                end
            end
        end
        if (!rst) begin
            if (req0_valid && req0_ready) sb.push_back({1'b0, model(req0_op, req0_data, req0_shamt)});
            if (req1_valid && req1_ready) sb.push_back({1'b1, model(req1_op, req1_data, req1_shamt)});
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        req0_valid = 0; req1_valid = 0;
        req0_op = 0; req1_op = 0;
        req0_data = 0; req1_data = 0;
        req0_shamt = 0; req1_shamt = 0;
    endtask

    task automatic drain();
        idle_inputs();
        rsp_ready = 1;
        repeat (3) cycle();
    endtask

    task automatic test_reset();
        rst = 1; rsp_ready = 1;
        req0_valid = 1; req1_valid = 1;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL reset_ready: got %b, required 00", {req0_ready, req1_ready});
        end
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_id, rsp_data} !== 34'h0) begin
            errors++;
            $display("[TB] FAIL reset_rsp: got v=%b id=%b data=%h, required 0 0 0", rsp_valid, rsp_id, rsp_data);
        end
        rst = 0;
        idle_inputs();
        cycle();
    endtask

    task automatic test_sll();
        rsp_ready = 1;
        req0_valid = 1; req0_op = 2'b00; req0_data = 32'h0000_0001; req0_shamt = 5'd31;
        cycle();
        checks++;
        if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b0, 32'h8000_0000}) begin
            errors++;
            $display("[TB] FAIL sll_latency: got v=%b id=%b data=%h, required 1 0 80000000", rsp_valid, rsp_id, rsp_data);
        end
        drain();
    endtask

    task automatic test_right_shifts();
        logic [1:0]  ops [6]  = '{2'b10, 2'b01, 2'b10, 2'b00, 2'b01, 2'b10};
        logic [31:0] vals [6] = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        logic [4:0]  sh [6]   = '{5'd4, 5'd4, 5'd31, 5'd0, 5'd0, 5'd0};
        logic [31:0] req [6]  = '{32'hF800_0000, 32'h0800_0000, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        rsp_ready = 1;
        for (int i = 0; i < 6; i++) begin
            req1_valid = 1; req1_op = ops[i]; req1_data = vals[i]; req1_shamt = sh[i];
            cycle();
            checks++;
            if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b1, req[i]}) begin
                errors++;
                $display("[TB] FAIL right_shift_%0d: got v=%b id=%b data=%h, required 1 1 %h",
                         i, rsp_valid, rsp_id, rsp_data, req[i]);
            end
        end
        drain();
    endtask

    task automatic test_rotate();
        logic [31:0] req;
`ifdef SHIFT_ROR_EN
        req = 32'h1000_000F;
`else
        req = 32'h0;
`endif
        rsp_ready = 1;
        req0_valid = 1; req0_op = 2'b11; req0_data = 32'h0000_00F1; req0_shamt = 5'd4;
        cycle();
        checks++;
        if ({rsp_valid, rsp_data} !== {1'b1, req}) begin
            errors++;
            $display("[TB] FAIL rotate: got v=%b data=%h, required 1 %h", rsp_valid, rsp_data, req);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        rst = 1; cycle(); rst = 0;
        rsp_ready = 1;
        req0_valid = 1; req1_valid = 1;
        for (int i = 0; i < 4; i++) begin
            req0_op = 2'(i); req0_data = 32'h1234_5678 + i; req0_shamt = 5'(i + 1);
            req1_op = 2'(i + 1); req1_data = 32'h8765_4321 - i; req1_shamt = 5'(i + 3);
            #1;
            checks++;
            if ({req0_ready, req1_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                errors++;
                $display("[TB] FAIL rr_grant_%0d: got ready0/1=%b, required %b",
                         i, {req0_ready, req1_ready}, (i % 2 == 0) ? 2'b10 : 2'b01);
            end
            cycle();
            checks++;
            if ({rsp_valid, rsp_id} !== {1'b1, 1'(i % 2)}) begin
                errors++;
                $display("[TB] FAIL rr_rsp_%0d: got v=%b id=%b, required 1 %0d", i, rsp_valid, rsp_id, i % 2);
            end
        end
        drain();
    endtask

    task automatic test_backpressure();
        logic [31:0] held;
        rsp_ready = 0;
        req0_valid = 1; req0_op = 2'b00; req0_data = 32'h0000_00A5; req0_shamt = 5'd8;
        cycle();
        held = rsp_data;
        req1_valid = 1; req1_op = 2'b01; req1_data = 32'hF000_0000; req1_shamt = 5'd2;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({req0_ready, req1_ready} !== 2'b00) begin
                errors++;
                $display("[TB] FAIL stall_ready_%0d: got %b, required 00", i, {req0_ready, req1_ready});
            end
            cycle();
            checks++;
            if ({rsp_valid, rsp_data} !== {1'b1, held}) begin
                errors++;
                $display("[TB] FAIL stall_hold_%0d: got v=%b data=%h, required 1 %h", i, rsp_valid, rsp_data, held);
            end
        end
        rsp_ready = 1;
        #1;
        checks++;
        if ((req0_ready ^ req1_ready) !== 1'b1) begin
            errors++;
            $display("[TB] FAIL drain_grant: got ready0/1=%b, required exactly one", {req0_ready, req1_ready});
        end
        cycle();
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL drain_refill: got rsp_valid=%b, required 1", rsp_valid);
        end
        drain();
    endtask

    task automatic test_reset_full();
        rsp_ready = 0;
        req0_valid = 1; req0_op = 2'b00; req0_data = 32'h0000_0003; req0_shamt = 5'd1;
        cycle();
        req1_valid = 1; req1_op = 2'b01; req1_data = 32'h0000_0100; req1_shamt = 5'd4;
        rst = 1; rsp_ready = 1;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL rst_full_ready: got %b, required 00", {req0_ready, req1_ready});
        end
        cycle();
        sb.delete();
        rst = 0;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rst_full_valid: got %b, required 0", rsp_valid);
        end
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL rst_full_ptr: got ready0/1=%b, required 10", {req0_ready, req1_ready});
        end
        cycle();
        drain();
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            req0_valid = 1'($urandom_range(0, 1)); req0_op = 2'($urandom);
            req0_data = $urandom; req0_shamt = 5'($urandom);
            req1_valid = 1'($urandom_range(0, 1)); req1_op = 2'($urandom);
            req1_data = $urandom; req1_shamt = 5'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            checks++;
            if ((req0_ready && req1_ready) !== 1'b0) begin
                errors++;
                $display("[TB] FAIL one_hot_ready_%0d: got ready0/1=%b, required at most one", i, {req0_ready, req1_ready});
            end
            cycle();
        end
        drain();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL sb_leftover: got %0d pending, required 0", sb.size());
        end
    endtask

    initial begin
        rst = 1; rsp_ready = 0;
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_sll();
        test_right_shifts();
        test_rotate();
        test_back_to_back();
        test_backpressure();
        test_reset_full();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
